// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO: radix-2 shift-add multiply, restoring divide.
// Optional MIPS_MULDIV_EARLY_OUT_EN: multiplies stop once the remaining multiplier bits are zero.
module mips_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic               is_div;
  logic               neg_lo;
  logic               neg_hi;
  logic               div_zero;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplr;

  logic               is_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] mcand_next;
  logic [WIDTH-1:0]   mplr_next;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   hi_res;
  logic [WIDTH-1:0]   lo_res;
  logic               early_stop;
  logic               last_iter;

  assign is_signed = ~op[0];
  assign a_neg     = is_signed & a[WIDTH-1];
  assign b_neg     = is_signed & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  // Multiply keeps mcand pre-shifted so acc is always the exact partial product,
  // which lets an early exit commit without any realignment shift.
  always_comb begin
    acc_next   = acc;
    mcand_next = mcand;
    mplr_next  = mplr;
    shifted    = {acc[WIDTH-1:0], mplr[WIDTH-1]};
    diff       = shifted - {1'b0, mcand[WIDTH-1:0]};
    if (is_div) begin
      acc_next   = {{WIDTH{1'b0}}, (diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0])};
      mplr_next  = {mplr[WIDTH-2:0], ~diff[WIDTH]};
    end else begin
      acc_next   = mplr[0] ? acc + mcand : acc;
      mcand_next = mcand << 1;
      mplr_next  = mplr >> 1;
    end
  end

`ifdef MIPS_MULDIV_EARLY_OUT_EN
  assign early_stop = ~is_div && (mplr_next == '0);
`else
  assign early_stop = 1'b0;
`endif

  assign last_iter = (count == CNT_W'(1)) || early_stop;

  // A zero divisor drives the quotient to all ones and the remainder to |a|;
  // the dividend-sign fix then returns a itself, so only LO needs forcing.
  always_comb begin
    prod_fix = neg_lo ? -acc_next : acc_next;
    quo_fix  = neg_lo ? -mplr_next : mplr_next;
    rem_fix  = neg_hi ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
    hi_res   = prod_fix[2*WIDTH-1:WIDTH];
    lo_res   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      hi_res = rem_fix;
      lo_res = div_zero ? '1 : quo_fix;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      count    <= '0;
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mplr     <= '0;
    end else if (en) begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                state    <= RUN;
                busy     <= 1'b1;
                count    <= CNT_W'(WIDTH);
                is_div   <= op[1];
                neg_lo   <= a_neg ^ b_neg;
                neg_hi   <= a_neg;
                div_zero <= (b == '0);
                acc      <= '0;
                mcand    <= {{WIDTH{1'b0}}, (op[1] ? b_mag : a_mag)};
                mplr     <= op[1] ? a_mag : b_mag;
              end
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            acc   <= acc_next;
            mcand <= mcand_next;
            mplr  <= mplr_next;
            count <= count - CNT_W'(1);
            if (last_iter) begin
              hi    <= hi_res;
              lo    <= lo_res;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed-vector bench for mips_muldiv_unit (WIDTH=32): results, latency, abort, stall, reset.
module tb_mips_muldiv_unit;

  localparam int W     = 32;
  localparam int NEVER = 1000;

  logic          clk;
  logic          reset;
  logic          en;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          abort;
  logic          busy;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int vectors;
  int miscompares;
  int lat;
  logic busy1;
  logic seen_done;
  int lat_53;
  int lat_50;
  int lat_23;

  mips_muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .abort (abort),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Issues one operation and follows it until busy drops; returns the cycle number
  // (accept edge = 0) in which busy fell, which is the done cycle for a completed op.
  task automatic applyStimulus(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                               input int stray_cyc, input int abort_cyc, input int stall_cyc,
                               output int cyc, output logic busy_c1);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    busy_c1 = busy;
    cyc = 1;
    while (busy && cyc < 200) begin
      en = !(cyc >= stall_cyc && cyc < stall_cyc + 3);
      if (cyc == stray_cyc) begin
        start = 1'b1; op = 3'b001; a = 32'd9;
      end
      if (cyc == abort_cyc) abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0; en = 1'b1;
      cyc++;
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1; en = 1'b1; start = 1'b0; op = 3'b000; a = '0; b = '0; abort = 1'b0;
`ifdef MIPS_MULDIV_EARLY_OUT_EN
    lat_53 = 3; lat_50 = 2; lat_23 = 3;
`else
    lat_53 = 33; lat_50 = 33; lat_23 = 33;
`endif

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk); reset = 1'b0;

    applyStimulus(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, NEVER, NEVER, NEVER, lat, busy1);
    checkOutput("multu_busy_c1", 64'(busy1), 64'd1);
    checkOutput("multu_latency", 64'(lat), 64'd33);
    checkOutput("multu_done", 64'(done), 64'd1);
    checkOutput("multu_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);

    applyStimulus(3'b000, 32'hFFFFFFFD, 32'd7, NEVER, NEVER, NEVER, lat, busy1);
    checkOutput("mult_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);

    applyStimulus(3'b010, 32'hFFFFFFF9, 32'd2, NEVER, NEVER, NEVER, lat, busy1);
    checkOutput("div_neg_lat", 64'(lat), 64'd33);
    checkOutput("div_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

    applyStimulus(3'b011, 32'd7, 32'd0, NEVER, NEVER, NEVER, lat, busy1);
    checkOutput("divu_zero", {hi, lo}, 64'h00000007_FFFFFFFF);

    applyStimulus(3'b010, 32'h80000000, 32'hFFFFFFFF, NEVER, NEVER, NEVER, lat, busy1);
    checkOutput("div_ovf", {hi, lo}, 64'h00000000_80000000);

    applyStimulus(3'b010, 32'hFFFFFFF9, 32'd0, NEVER, NEVER, NEVER, lat, busy1);
    checkOutput("div_zero_signed", {hi, lo}, 64'hFFFFFFF9_FFFFFFFF);

    // MTHI in the done cycle of the previous divide; LO must keep all ones
    @(negedge clk);
    start = 1'b1; op = 3'b100; a = 32'h12345678;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("mthi_hilo", {hi, lo}, 64'h12345678_FFFFFFFF);
    checkOutput("mthi_busy_done", {62'd0, busy, done}, 64'd0);

    @(negedge clk);
    start = 1'b1; op = 3'b101; a = 32'hCAFEF00D;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("mtlo_hilo", {hi, lo}, 64'h12345678_CAFEF00D);

    @(negedge clk);
    start = 1'b1; op = 3'b110; a = 32'h0BADBEEF;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("invalid_op", {31'd0, busy, hi, lo[31:0]} , {31'd0, 1'b0, 32'h12345678, 32'hCAFEF00D});

    @(negedge clk);
    start = 1'b1; op = 3'b101; a = 32'd0;
    @(posedge clk); #1;
    start = 1'b0;

    applyStimulus(3'b001, 32'd2, 32'd3, (lat_23 > 5) ? 5 : NEVER, NEVER, NEVER, lat, busy1);
    checkOutput("multu_stray_lat", 64'(lat), 64'(lat_23));
    checkOutput("multu_stray", {hi, lo}, 64'h00000000_00000006);

    applyStimulus(3'b001, 32'd5, 32'h80000000, NEVER, 10, NEVER, lat, busy1);
    checkOutput("abort_lat", 64'(lat), 64'd11);
    checkOutput("abort_done", 64'(done), 64'd0);
    checkOutput("abort_hilo", {hi, lo}, 64'h00000000_00000006);

    // Abort while idle is harmless, and a start in the same cycle is still taken
    @(negedge clk); abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checkOutput("idle_abort", {30'd0, busy, done, hi}, {30'd0, 1'b0, 1'b0, 32'd0});

    // Reset in cycle 10 of a DIVU must discard the operation without a done
    @(negedge clk);
    start = 1'b1; abort = 1'b1; op = 3'b011; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    checkOutput("abort_start_idle", 64'(busy), 64'd1);
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst_busy_done", {62'd0, busy, done}, 64'd0);
    checkOutput("midrst_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    checkOutput("midrst_no_done", 64'(seen_done), 64'd0);

    applyStimulus(3'b011, 32'd100, 32'd7, NEVER, NEVER, 5, lat, busy1);
    checkOutput("stall_lat", 64'(lat), 64'd36);
    checkOutput("stall_hilo", {hi, lo}, 64'h00000002_0000000E);

    applyStimulus(3'b001, 32'd5, 32'd3, NEVER, NEVER, NEVER, lat, busy1);
    checkOutput("early53_lat", 64'(lat), 64'(lat_53));
    checkOutput("early53_hilo", {hi, lo}, 64'h00000000_0000000F);

    applyStimulus(3'b001, 32'd5, 32'd0, NEVER, NEVER, NEVER, lat, busy1);
    checkOutput("early50_busy_c1", 64'(busy1), 64'd1);
    checkOutput("early50_lat", 64'(lat), 64'(lat_50));
    checkOutput("early50_hilo", {hi, lo}, 64'd0);
    @(posedge clk); #1;
    checkOutput("done_pulse_width", 64'(done), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
